// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, FSM state type and address field helpers for the data cache
package dcache_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 6;
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam int LINES  = 1 << IDX_W;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:IDX_W+2];
    endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped valid/tag/data storage, async read by index, sync write
module dcache_array
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);
    logic [LINES-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [TAG_W-1:0]  tag_d  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [DATA_W-1:0] data_d [LINES];

    // a write always leaves the line valid with the written tag and data
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_data;
        end
    end

    // valid bits clear asynchronously so reset invalidates the whole cache at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // tag and data need no reset since valid gates every use
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-allocate data cache with SRAM req/ack backend
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_wr_q, is_wr_d;
    logic              sram_req_q, sram_req_d;
    logic              sram_we_q, sram_we_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic [ADDR_W-1:0] lk_addr, aligned;
    logic              rd_valid, hit, arr_we, idle_hit;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_data;

    assign aligned  = addr & ~ADDR_W'(3);
    assign lk_addr  = (state_q == IDLE) ? addr : addr_q;
    assign hit      = rd_valid && (rd_tag == get_tag(lk_addr));
    assign idle_hit = (state_q == IDLE) && mem_r_en && !mem_w_en && hit;

    dcache_array u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (get_idx(lk_addr)),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .we       (arr_we),
        .wr_idx   (get_idx(addr_q)),
        .wr_tag   (get_tag(addr_q)),
        .wr_data  (is_wr_q ? sram_wdata_q : sram_rdata)
    );

    // next-state: latch the request in IDLE, hold SRAM signals until ack, one DONE cycle
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        is_wr_d      = is_wr_q;
        sram_req_d   = sram_req_q;
        sram_we_d    = sram_we_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        arr_we       = 1'b0;
        case (state_q)
            IDLE: if (mem_w_en || (mem_r_en && !hit)) begin
                state_d      = mem_w_en ? WR : RD;
                addr_d       = aligned;
                is_wr_d      = mem_w_en;
                sram_req_d   = 1'b1;
                sram_we_d    = mem_w_en;
                sram_addr_d  = aligned;
                sram_wdata_d = mem_w_en ? wdata : sram_wdata_q;
            end
            RD: if (sram_ack) begin
                state_d    = DONE;
                sram_req_d = 1'b0;
                arr_we     = 1'b1;
            end
            WR: if (sram_ack) begin
                state_d    = DONE;
                sram_req_d = 1'b0;
                sram_we_d  = 1'b0;
                arr_we     = hit;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered SRAM interface; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            is_wr_q      <= 1'b0;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            is_wr_q      <= is_wr_d;
            sram_req_q   <= sram_req_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign ready      = (state_q == DONE) || ((state_q == IDLE) && !mem_w_en && !(mem_r_en && !hit));
    assign rdata      = (idle_hit || (state_q == DONE && !is_wr_q)) ? rd_data : '0;
    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed checks of hit/miss latency, write-through, eviction and reset abort
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] sram_rdata = '0;
    logic        sram_ack = 1'b0;
    logic [31:0] rdata, sram_addr, sram_wdata;
    logic        ready, sram_req, sram_we;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_req   (sram_req),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_ack   (sram_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // one access held through DONE; SRAM acks in the dly-th request cycle with rsp
    task automatic access(input string tag, input logic wr, input logic both,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] rsp,
                          input int dly, input logic [31:0] exp_rd, input int exp_low);
        int          low = 0;
        int          reqs = 0;
        int          txns = 0;
        logic        prev = 1'b0;
        logic        bad = 1'b0;
        logic        done = 1'b0;
        logic [31:0] rd = '0;
        @(posedge clk); #1;
        mem_w_en = wr;
        mem_r_en = !wr || both;
        addr     = a;
        wdata    = d;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (sram_req) begin
                reqs++;
                if (!prev) txns++;
                if (sram_we !== wr || sram_addr !== (a & ~32'h3) || (wr && sram_wdata !== d)) bad = 1'b1;
            end
            prev = sram_req;
            if (ready) begin
                rd   = rdata;
                done = 1'b1;
            end else begin
                low++;
                if (sram_req && reqs == dly) begin
                    sram_ack   = 1'b1;
                    sram_rdata = rsp;
                    @(posedge clk); #1;
                    sram_ack   = 1'b0;
                    sram_rdata = '0;
                end
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_ready_low"}, low, exp_low);
        check({tag, "_req_cycles"}, reqs, (exp_low == 0) ? 0 : dly);
        check({tag, "_txns"}, txns, (exp_low == 0) ? 0 : 1);
        check({tag, "_sram_fields"}, 32'(bad), 32'd0);
        if (!wr) check({tag, "_rdata"}, rd, exp_rd);
        @(posedge clk); #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        @(negedge clk);
        check({tag, "_no_reissue"}, 32'(sram_req), 32'd0);
        check({tag, "_idle_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req", 32'(sram_req), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        check("rst_addr", sram_addr, 32'd0);
        check("rst_wdata", sram_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        rst = 1'b1;

        access("t1_rd_miss", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 32'hDEADBEEF, 4);
        access("t2_rd_hit", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0);
        access("t3_wr_hit", 1'b1, 1'b0, 32'h100, 32'h12345678, 32'h0, 2, 32'h0, 3);
        access("t3_rd_hit", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1, 32'h12345678, 0);

        @(posedge clk); #1;
        sram_ack   = 1'b1;
        sram_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        sram_ack   = 1'b0;
        sram_rdata = '0;
        @(negedge clk);
        check("stray_ack_req", 32'(sram_req), 32'd0);
        check("stray_ack_ready", 32'(ready), 32'd1);
        access("stray_hit", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1, 32'h12345678, 0);

        access("t4_wr_miss", 1'b1, 1'b0, 32'h500, 32'hAAAA5555, 32'h0, 1, 32'h0, 2);
        access("t4_old_line", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1, 32'h12345678, 0);
        access("t4_rd_miss", 1'b0, 1'b0, 32'h500, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 2);

        access("t5_rd_100", 1'b0, 1'b0, 32'h100, 32'h0, 32'h11111111, 1, 32'h11111111, 2);
        access("t5_rd_500", 1'b0, 1'b0, 32'h500, 32'h0, 32'h22222222, 2, 32'h22222222, 3);
        access("t5_hit_500", 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 1, 32'h22222222, 0);
        access("t5_rd_100_again", 1'b0, 1'b0, 32'h100, 32'h0, 32'h33333333, 1, 32'h33333333, 2);

        access("both_wr_wins", 1'b1, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0, 1, 32'h0, 2);
        access("both_no_alloc", 1'b0, 1'b0, 32'h104, 32'h0, 32'h00000055, 1, 32'h00000055, 2);
        access("offset_ignored", 1'b0, 1'b0, 32'h107, 32'h0, 32'h0, 1, 32'h00000055, 0);

        @(posedge clk); #1;
        mem_r_en = 1'b1;
        addr     = 32'h200;
        @(negedge clk);
        @(negedge clk);
        check("t6_req_before", 32'(sram_req), 32'd1);
        #2 rst = 1'b0;
        #1 check("t6_req_async", 32'(sram_req), 32'd0);
        mem_r_en = 1'b0;
        #1 check("t6_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        sram_ack   = 1'b1;
        sram_rdata = 32'h99999999;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        sram_ack   = 1'b0;
        sram_rdata = '0;
        @(negedge clk);
        check("t6_late_ack_req", 32'(sram_req), 32'd0);
        check("t6_late_ack_ready", 32'(ready), 32'd1);
        check("t6_late_ack_rdata", rdata, 32'd0);
        access("t6_cleared", 1'b0, 1'b0, 32'h100, 32'h0, 32'h44444444, 1, 32'h44444444, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
